// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS BCD stopwatch.
//   bcd_t       - one BCD digit (0..9)
//   sw_state_t  - control FSM states
//   tens_of / ones_of - split a small decimal constant into BCD digits
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        LAP  = 2'd3
    } sw_state_t;

    localparam int SEC_ONES_MAX = 9;
    localparam int SEC_TENS_MAX = 5;
    localparam int MIN_ONES_MAX = 9;
    localparam int MIN_TENS_MAX = 9;

    // Used at elaboration time to turn MAX_MIN into a BCD digit pair.
    function automatic bcd_t tens_of(input int value);
        return bcd_t'((value / 10) % 10);
    endfunction

    function automatic bcd_t ones_of(input int value);
        return bcd_t'(value % 10);
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit counter that counts 0..MAX and wraps to 0.
// Ports:
//   i_clk      - system clock
//   i_reset_n  - synchronous active-low reset, digit -> 0
//   i_clr      - synchronous clear, digit -> 0 (wins over i_inc)
//   i_inc      - advance the digit by one at this edge
//   o_digit    - current registered digit value
//   o_carry    - combinational: i_inc while the digit sits at MAX, i.e. this
//                edge wraps the digit and the next digit up must advance
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clr,
    input  logic i_inc,
    output bcd_t o_digit,
    output logic o_carry
);

    localparam bcd_t MAX_D = bcd_t'(MAX);

    bcd_t digit_reg;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_clr) begin
            digit_reg <= '0;
        end else if (i_inc) begin
            // Wrapping at MAX keeps the digit inside its legal BCD range.
            digit_reg <= (digit_reg == MAX_D) ? '0 : digit_reg + 4'd1;
        end
    end

    assign o_digit = digit_reg;
    assign o_carry = i_inc && (digit_reg == MAX_D);

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS stopwatch counting one second per i_tick pulse, 00:00 .. MAX_MIN:59.
// Ports:
//   i_clk         - system clock
//   i_reset_n     - synchronous active-low reset (count, snapshot, FSM)
//   i_tick        - one-cycle time-base pulse; counted in RUN and LAP
//   i_start_stop  - pulse: toggles run/stop
//   i_clear       - pulse: zeroes the count, only honoured in STOP
//   i_lap         - pulse: freeze / unfreeze the display while running
//   o_sec_ones .. o_min_tens - displayed BCD digits (snapshot in LAP, else live)
//   o_running     - high in RUN and LAP
//   o_wrap        - one-cycle pulse in the cycle after MAX_MIN:59 -> 00:00
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_tick,
    input  logic i_start_stop,
    input  logic i_clear,
    input  logic i_lap,
    output bcd_t o_sec_ones,
    output bcd_t o_sec_tens,
    output bcd_t o_min_ones,
    output bcd_t o_min_tens,
    output logic o_running,
    output logic o_wrap
);

    localparam bcd_t MAX_MIN_TENS = tens_of(MAX_MIN);
    localparam bcd_t MAX_MIN_ONES = ones_of(MAX_MIN);

    sw_state_t state_reg;
    sw_state_t state_next;
    logic      snap_capture;
    logic      zero_all;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Priority clear > start_stop > lap is applied among the pulses that
    // have an effect in the current state; a pulse that a state ignores
    // does not mask a lower-priority one.
    always_comb begin
        state_next   = state_reg;
        snap_capture = 1'b0;
        zero_all     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_start_stop) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (i_start_stop) begin
                    state_next = STOP;
                end else if (i_lap) begin
                    state_next   = LAP;
                    snap_capture = 1'b1;
                end
            end
            LAP: begin
                if (i_start_stop) begin
                    state_next = STOP;
                end else if (i_lap) begin
                    state_next = RUN;
                end
            end
            STOP: begin
                if (i_clear) begin
                    state_next = IDLE;
                    zero_all   = 1'b1;
                end else if (i_start_stop) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Live count: sec_ones -> sec_tens -> min_ones -> min_tens
    // ------------------------------------------------------------------
    // Counting qualifies on the current state, so a tick that coincides
    // with leaving RUN/LAP still counts and one that coincides with
    // entering RUN from STOP/IDLE does not.
    logic count_en;
    assign count_en = i_tick && ((state_reg == RUN) || (state_reg == LAP));

    bcd_t live_sec_ones;
    bcd_t live_sec_tens;
    bcd_t live_min_ones;
    bcd_t live_min_tens;
    logic sec_ones_carry;
    logic sec_tens_carry;
    logic min_ones_carry;
    logic min_tens_carry;
    logic min_at_max;
    logic wrap_event;
    logic min_ones_inc;
    logic min_clr;

    // Minutes are a plain 00..99 BCD pair; the wrap point is enforced here
    // by clearing both digits instead of letting them advance.
    assign min_at_max   = (live_min_tens == MAX_MIN_TENS) && (live_min_ones == MAX_MIN_ONES);
    assign wrap_event   = sec_tens_carry && min_at_max;
    assign min_ones_inc = sec_tens_carry && !min_at_max;
    assign min_clr      = zero_all || wrap_event;

    bcd_digit_counter #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clr     (zero_all),
        .i_inc     (count_en),
        .o_digit   (live_sec_ones),
        .o_carry   (sec_ones_carry)
    );

    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clr     (zero_all),
        .i_inc     (sec_ones_carry),
        .o_digit   (live_sec_tens),
        .o_carry   (sec_tens_carry)
    );

    bcd_digit_counter #(.MAX(MIN_ONES_MAX)) u_min_ones (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clr     (min_clr),
        .i_inc     (min_ones_inc),
        .o_digit   (live_min_ones),
        .o_carry   (min_ones_carry)
    );

    bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clr     (min_clr),
        .i_inc     (min_ones_carry),
        .o_digit   (live_min_tens),
        .o_carry   (min_tens_carry)
    );

    // The top minute digit never needs to carry further; the wrap is
    // detected via min_at_max above.
    logic unused_carry;
    assign unused_carry = min_tens_carry;

    // ------------------------------------------------------------------
    // Wrap pulse, registered so it appears alongside the 00:00 count
    // ------------------------------------------------------------------
    logic wrap_reg;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wrap_reg <= 1'b0;
        end else begin
            wrap_reg <= wrap_event;
        end
    end

    // ------------------------------------------------------------------
    // Lap snapshot and display mux
    // ------------------------------------------------------------------
    bcd_t live_digits [4];
    bcd_t disp_digits [4];
    logic show_snapshot;

    assign live_digits[0] = live_sec_ones;
    assign live_digits[1] = live_sec_tens;
    assign live_digits[2] = live_min_ones;
    assign live_digits[3] = live_min_tens;
    assign show_snapshot  = (state_reg == LAP);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_snap
            bcd_t snap_reg;

            // Captures the pre-edge live value, i.e. the count shown at the
            // moment lap was pressed.
            always_ff @(posedge i_clk) begin
                if (!i_reset_n || zero_all) begin
                    snap_reg <= '0;
                end else if (snap_capture) begin
                    snap_reg <= live_digits[gi];
                end
            end

            assign disp_digits[gi] = show_snapshot ? snap_reg : live_digits[gi];
        end
    endgenerate

    assign o_sec_ones = disp_digits[0];
    assign o_sec_tens = disp_digits[1];
    assign o_min_ones = disp_digits[2];
    assign o_min_tens = disp_digits[3];
    assign o_running  = (state_reg == RUN) || (state_reg == LAP);
    assign o_wrap     = wrap_reg;

endmodule

// File: tb/tb_stopwatch_bcd.sv
module tb_stopwatch_bcd;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_tick = 1'b0;
    logic       i_start_stop = 1'b0;
    logic       i_clear = 1'b0;
    logic       i_lap = 1'b0;
    logic [3:0] o_sec_ones;
    logic [3:0] o_sec_tens;
    logic [3:0] o_min_ones;
    logic [3:0] o_min_tens;
    logic       o_running;
    logic       o_wrap;

    stopwatch_bcd #(.MAX_MIN(59)) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_tick       (i_tick),
        .i_start_stop (i_start_stop),
        .i_clear      (i_clear),
        .i_lap        (i_lap),
        .o_sec_ones   (o_sec_ones),
        .o_sec_tens   (o_sec_tens),
        .o_min_ones   (o_min_ones),
        .o_min_tens   (o_min_tens),
        .o_running    (o_running),
        .o_wrap       (o_wrap)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string       nm;
        logic [15:0] d;   // MMSS as four BCD nibbles
        logic        r;
        logic        w;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic [15:0] disp;
    assign disp = {o_min_tens, o_min_ones, o_sec_tens, o_sec_ones};

    // Monitor: every cycle checks digit legality, and compares any expected
    // responses queued for the edge just taken.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge i_clk);
            vectors++;
            if (o_sec_ones > 4'd9 || o_sec_tens > 4'd5 || o_min_ones > 4'd9 || o_min_tens > 4'd9) begin
                miscompares++;
                $display("FAIL bcd_legal: got %h required all digits BCD with sec_tens<=5", disp);
            end
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                vectors++;
                if (disp !== e.d || o_running !== e.r || o_wrap !== e.w) begin
                    miscompares++;
                    $display("FAIL %s: got %h run=%b wrap=%b required %h run=%b wrap=%b",
                             e.nm, disp, o_running, o_wrap, e.d, e.r, e.w);
                end else begin
                    $display("ok   %s: %h run=%b wrap=%b", e.nm, disp, o_running, o_wrap);
                end
            end
        end
    end

    // One clock of stimulus; inputs are driven 1 time unit after an edge.
    task automatic step(input bit ss, input bit clr, input bit lp, input bit tk);
        i_start_stop = ss;
        i_clear      = clr;
        i_lap        = lp;
        i_tick       = tk;
        @(posedge i_clk);
        #1;
        i_start_stop = 1'b0;
        i_clear      = 1'b0;
        i_lap        = 1'b0;
        i_tick       = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic [15:0] d, input logic r, input logic w);
        exp_t e;
        e.nm = nm;
        e.d  = d;
        e.r  = r;
        e.w  = w;
        sb_q.push_back(e);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1);
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
    endtask

    initial begin : driver
        @(posedge i_clk);
        #1;
        do_reset();
        expect_out("reset", 16'h0000, 0, 0);

        // Start and count five seconds, checking latency each tick.
        step(1, 0, 0, 0);                 expect_out("start", 16'h0000, 1, 0);
        step(0, 0, 0, 1);                 expect_out("tick1", 16'h0001, 1, 0);
        step(0, 0, 0, 1);                 expect_out("tick2", 16'h0002, 1, 0);
        step(0, 0, 0, 1);                 expect_out("tick3", 16'h0003, 1, 0);
        step(0, 0, 0, 1);                 expect_out("tick4", 16'h0004, 1, 0);
        step(0, 0, 0, 1);                 expect_out("tick5", 16'h0005, 1, 0);
        do_reset();                       expect_out("reset_midrun", 16'h0000, 0, 0);
        step(0, 0, 0, 1);                 expect_out("idle_tick_ignored", 16'h0000, 0, 0);

        // Minute carries.
        step(1, 0, 0, 0);
        ticks(59);                        expect_out("at_0059", 16'h0059, 1, 0);
        step(0, 0, 0, 1);                 expect_out("carry_0100", 16'h0100, 1, 0);
        ticks(539);                       expect_out("at_0959", 16'h0959, 1, 0);
        step(0, 0, 0, 1);                 expect_out("carry_1000", 16'h1000, 1, 0);

        // Wrap at 59:59.
        ticks(2999);                      expect_out("at_5959", 16'h5959, 1, 0);
        step(0, 0, 0, 1);                 expect_out("wrap", 16'h0000, 1, 1);
        step(0, 0, 0, 0);                 expect_out("wrap_one_cycle", 16'h0000, 1, 0);

        // Lap freeze / unfreeze.
        ticks(10);                        expect_out("at_0010", 16'h0010, 1, 0);
        step(0, 0, 1, 0);                 expect_out("lap_enter", 16'h0010, 1, 0);
        step(0, 0, 0, 1);                 expect_out("lap_frozen1", 16'h0010, 1, 0);
        step(0, 0, 0, 1);                 expect_out("lap_frozen2", 16'h0010, 1, 0);
        step(0, 0, 0, 1);                 expect_out("lap_frozen3", 16'h0010, 1, 0);
        step(0, 0, 1, 0);                 expect_out("lap_exit", 16'h0013, 1, 0);
        step(0, 0, 0, 1);                 expect_out("lap_resumed", 16'h0014, 1, 0);
        step(0, 0, 1, 0);                 expect_out("lap_again", 16'h0014, 1, 0);
        step(0, 0, 0, 1);                 expect_out("lap_frozen4", 16'h0014, 1, 0);
        step(1, 0, 0, 0);                 expect_out("lap_to_stop_live", 16'h0015, 0, 0);

        // Stop with coincident tick, then clear.
        do_reset();
        step(1, 0, 0, 0);
        ticks(7);                         expect_out("at_0007", 16'h0007, 1, 0);
        step(1, 0, 0, 1);                 expect_out("stop_with_tick", 16'h0008, 0, 0);
        step(0, 0, 0, 1);                 expect_out("stop_tick_ignored1", 16'h0008, 0, 0);
        step(0, 0, 0, 1);                 expect_out("stop_tick_ignored2", 16'h0008, 0, 0);
        step(0, 1, 0, 0);                 expect_out("clear_in_stop", 16'h0000, 0, 0);
        step(0, 0, 1, 0);                 expect_out("idle_lap_ignored", 16'h0000, 0, 0);
        step(1, 0, 0, 1);                 expect_out("start_tick_not_counted", 16'h0000, 1, 0);
        ticks(3);                         expect_out("at_0003", 16'h0003, 1, 0);
        step(0, 1, 0, 0);                 expect_out("clear_in_run_ignored", 16'h0003, 1, 0);
        step(0, 0, 0, 1);                 expect_out("after_clear_run", 16'h0004, 1, 0);

        // Simultaneous controls.
        step(1, 0, 0, 0);                 expect_out("stop_0004", 16'h0004, 0, 0);
        step(1, 1, 0, 0);                 expect_out("clear_beats_start", 16'h0000, 0, 0);
        step(1, 0, 0, 0);                 expect_out("restart", 16'h0000, 1, 0);
        step(0, 0, 0, 1);                 expect_out("restart_tick", 16'h0001, 1, 0);
        step(1, 0, 1, 0);                 expect_out("start_beats_lap", 16'h0001, 0, 0);
        step(1, 0, 0, 0);                 expect_out("resume", 16'h0001, 1, 0);
        step(0, 0, 0, 1);                 expect_out("resume_live", 16'h0002, 1, 0);

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge i_clk);
        #1;
        if (sb_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending entries required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
